// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU operation codes and a bit-mask helper for the MIPS core
package mips_pkg;

  localparam logic [5:0] ALU_OP_NOP   = 6'd0;
  localparam logic [5:0] ALU_OP_ADD   = 6'd1;
  localparam logic [5:0] ALU_OP_ADDU  = 6'd2;
  localparam logic [5:0] ALU_OP_SUB   = 6'd3;
  localparam logic [5:0] ALU_OP_SUBU  = 6'd4;
  localparam logic [5:0] ALU_OP_AND   = 6'd5;
  localparam logic [5:0] ALU_OP_OR    = 6'd6;
  localparam logic [5:0] ALU_OP_XOR   = 6'd7;
  localparam logic [5:0] ALU_OP_NOR   = 6'd8;
  localparam logic [5:0] ALU_OP_SLT   = 6'd9;
  localparam logic [5:0] ALU_OP_SLTU  = 6'd10;
  localparam logic [5:0] ALU_OP_SLL   = 6'd11;
  localparam logic [5:0] ALU_OP_SRL   = 6'd12;
  localparam logic [5:0] ALU_OP_SRA   = 6'd13;
  localparam logic [5:0] ALU_OP_SLLV  = 6'd14;
  localparam logic [5:0] ALU_OP_SRLV  = 6'd15;
  localparam logic [5:0] ALU_OP_SRAV  = 6'd16;
  localparam logic [5:0] ALU_OP_LUI   = 6'd17;
  localparam logic [5:0] ALU_OP_MULT  = 6'd18;
  localparam logic [5:0] ALU_OP_MULTU = 6'd19;
  localparam logic [5:0] ALU_OP_DIV   = 6'd20;
  localparam logic [5:0] ALU_OP_DIVU  = 6'd21;
  localparam logic [5:0] ALU_OP_MFHI  = 6'd22;
  localparam logic [5:0] ALU_OP_MFLO  = 6'd23;
  localparam logic [5:0] ALU_OP_MTHI  = 6'd24;
  localparam logic [5:0] ALU_OP_MTLO  = 6'd25;
  localparam logic [5:0] ALU_OP_EXT   = 6'd26;
  localparam logic [5:0] ALU_OP_INS   = 6'd27;

  // n low bits set; n may be 32 (all ones)
  function automatic logic [31:0] low_mask(input logic [5:0] n);
    return (n >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/alu_hilo.sv
// rtl/alu_hilo.sv - HI/LO register pair with the single-cycle multiply/divide datapath
module alu_hilo
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, quo_mag, rem_mag;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic        b_zero;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes: truncates toward zero and wraps 0x80000000 / -1 cleanly
  assign mag_a   = a[31] ? (32'd0 - a) : a;
  assign mag_b   = b[31] ? (32'd0 - b) : b;
  assign b_zero  = (b == 32'd0);
  assign quo_mag = b_zero ? 32'd0 : (mag_a / mag_b);
  assign rem_mag = b_zero ? 32'd0 : (mag_a % mag_b);
  assign quo_s   = (a[31] ^ b[31]) ? (32'd0 - quo_mag) : quo_mag;
  assign rem_s   = a[31] ? (32'd0 - rem_mag) : rem_mag;
  assign quo_u   = b_zero ? 32'd0 : (a / b);
  assign rem_u   = b_zero ? 32'd0 : (a % b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      case (alu_op)
        ALU_OP_MULT:  {hi, lo} <= prod_s;
        ALU_OP_MULTU: {hi, lo} <= prod_u;
        ALU_OP_DIV: if (!b_zero) begin
          lo <= quo_s;
          hi <= rem_s;
        end
        ALU_OP_DIVU: if (!b_zero) begin
          lo <= quo_u;
          hi <= rem_u;
        end
        ALU_OP_MTHI: hi <= a;
        ALU_OP_MTLO: lo <= a;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - combinational 32-bit MIPS ALU with branch/overflow flags and HI/LO access
module mips_alu
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  logic [4:0]  ins15_11,
  output logic [31:0] out,
  output logic        zero,
  output logic        great,
  output logic        overflow
);

  logic [31:0] hi, lo;
  logic [31:0] sum, diff, ins_field;
  logic        add_ovf, sub_ovf;

  alu_hilo u_hilo (
    .clk    (clk),
    .rst    (rst),
    .alu_op (alu_op),
    .a      (a),
    .b      (b),
    .hi     (hi),
    .lo     (lo)
  );

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);

  // INS field spans [ins15_11:shamt]; only meaningful when ins15_11 >= shamt
  assign ins_field = low_mask({1'b0, ins15_11} - {1'b0, shamt} + 6'd1) << shamt;

  always_comb begin
    out      = 32'd0;
    overflow = 1'b0;
    case (alu_op)
      ALU_OP_ADD:   begin out = sum;  overflow = add_ovf; end
      ALU_OP_ADDU:  out = sum;
      ALU_OP_SUB:   begin out = diff; overflow = sub_ovf; end
      ALU_OP_SUBU:  out = diff;
      ALU_OP_AND:   out = a & b;
      ALU_OP_OR:    out = a | b;
      ALU_OP_XOR:   out = a ^ b;
      ALU_OP_NOR:   out = ~(a | b);
      ALU_OP_SLT:   out = {31'd0, ($signed(a) < $signed(b))};
      ALU_OP_SLTU:  out = {31'd0, (a < b)};
      ALU_OP_SLL:   out = b << shamt;
      ALU_OP_SRL:   out = b >> shamt;
      ALU_OP_SRA:   out = 32'($signed(b) >>> shamt);
      ALU_OP_SLLV:  out = b << a[4:0];
      ALU_OP_SRLV:  out = b >> a[4:0];
      ALU_OP_SRAV:  out = 32'($signed(b) >>> a[4:0]);
      ALU_OP_LUI:   out = {b[15:0], 16'h0000};
      ALU_OP_MFHI:  out = hi;
      ALU_OP_MFLO:  out = lo;
      ALU_OP_EXT:   out = (a >> shamt) & low_mask({1'b0, ins15_11} + 6'd1);
      ALU_OP_INS: begin
        if (ins15_11 < shamt) out = b;
        else                  out = (b & ~ins_field) | ((a << shamt) & ins_field);
      end
      default: out = 32'd0;
    endcase
  end

  assign zero  = (out == 32'd0);
  assign great = ($signed(a) > $signed(b));

endmodule

// File: tb/tb_mips_alu.sv
// tb/tb_mips_alu.sv - randomized self-checking bench for mips_alu against an arithmetic reference model
module tb_mips_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  alu_op = 6'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic [4:0]  shamt = 5'd0, ins15_11 = 5'd0;
  logic [31:0] out;
  logic        zero, great, overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -MAXI - 64'sd1;

  mips_alu dut (
    .clk      (clk),
    .rst      (rst),
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .shamt    (shamt),
    .ins15_11 (ins15_11),
    .out      (out),
    .zero     (zero),
    .great    (great),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void ref_out(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                                  input int sh, input int msb, output logic [31:0] o, output logic ovf);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint r;
    o = 32'd0;
    ovf = 1'b0;
    case (op)
      1, 2: begin
        r = sx + sy; o = r[31:0];
        if (op == 1) ovf = (r > MAXI) || (r < MINI);
      end
      3, 4: begin
        r = sx - sy; o = r[31:0];
        if (op == 3) ovf = (r > MAXI) || (r < MINI);
      end
      5: o = x & y;
      6: o = x | y;
      7: o = x ^ y;
      8: o = ~(x | y);
      9: o = (sx < sy) ? 32'd1 : 32'd0;
      10: o = (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
      11, 12, 13, 14, 15, 16: begin
        int n = (op >= 14) ? int'(x[4:0]) : sh;
        for (int i = 0; i < 32; i++) begin
          if (op == 11 || op == 14) o[i] = (i >= n) ? y[i-n] : 1'b0;
          else if (op == 12 || op == 15) o[i] = (i + n <= 31) ? y[i+n] : 1'b0;
          else o[i] = (i + n <= 31) ? y[i+n] : y[31];
        end
      end
      17: o = y * 32'd65536;
      22: o = m_hi;
      23: o = m_lo;
      26: for (int i = 0; i < 32; i++) if (i <= msb && i + sh <= 31) o[i] = x[i+sh];
      27: begin
        o = y;
        if (msb >= sh) for (int i = sh; i <= msb; i++) o[i] = x[i-sh];
      end
      default: o = 32'd0;
    endcase
  endfunction

  function automatic void ref_hilo(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint unsigned ux = longint'(x);
    longint unsigned uy = longint'(y);
    longint p, q, r;
    longint unsigned up;
    case (op)
      18: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
      19: begin up = ux * uy; m_hi = up[63:32]; m_lo = up[31:0]; end
      20: if (y != 0) begin q = sx / sy; r = sx % sy; m_lo = q[31:0]; m_hi = r[31:0]; end
      21: if (y != 0) begin up = ux / uy; m_lo = up[31:0]; up = ux % uy; m_hi = up[31:0]; end
      24: m_hi = x;
      25: m_lo = x;
      default: ;
    endcase
  endfunction

  // drive at a negedge, settle, and compare all combinational outputs with the model
  task automatic drive(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] sh, input logic [4:0] msb);
    logic [31:0] eo;
    logic        eov;
    alu_op = op; a = x; b = y; shamt = sh; ins15_11 = msb;
    #1;
    ref_out(op, x, y, int'(sh), int'(msb), eo, eov);
    chk($sformatf("op%0d out", op), {32'd0, out}, {32'd0, eo});
    chk($sformatf("op%0d zero", op), {63'd0, zero}, {63'd0, (eo == 32'd0)});
    chk($sformatf("op%0d great", op), {63'd0, great}, {63'd0, (longint'($signed(x)) > longint'($signed(y)))});
    chk($sformatf("op%0d overflow", op), {63'd0, overflow}, {63'd0, eov});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) ref_hilo(alu_op, a, b);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 15));
      2: return edges[$urandom_range(0, 4)];
      default: return 32'd0 - 32'($urandom_range(1, 15));
    endcase
  endfunction

  initial begin
    @(negedge clk);
    drive(6'd22, 32'd0, 32'd0, 5'd0, 5'd0);
    chk("reset hi", {32'd0, out}, 64'd0);
    drive(6'd23, 32'd0, 32'd0, 5'd0, 5'd0);
    chk("reset lo", {32'd0, out}, 64'd0);
    rst = 1'b1;
    tick();

    drive(6'd1, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd0);
    chk("add ovf out", {32'd0, out}, 64'h8000_0000);
    chk("add ovf flag", {63'd0, overflow}, 64'd1);
    drive(6'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd0);
    chk("addu no ovf", {63'd0, overflow}, 64'd0);
    drive(6'd3, 32'd5, 32'd5, 5'd0, 5'd0);
    chk("sub zero", {63'd0, zero}, 64'd1);
    drive(6'd9, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd0);
    chk("slt", {32'd0, out}, 64'd1);
    drive(6'd10, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd0);
    chk("sltu", {32'd0, out}, 64'd0);
    drive(6'd0, 32'd3, 32'd0, 5'd0, 5'd0);
    chk("great", {63'd0, great}, 64'd1);
    drive(6'd13, 32'd0, 32'h8000_0000, 5'd4, 5'd0);
    chk("sra", {32'd0, out}, 64'hF800_0000);
    drive(6'd14, 32'h24, 32'd1, 5'd0, 5'd0);
    chk("sllv", {32'd0, out}, 64'h10);
    drive(6'd17, 32'd0, 32'h1234, 5'd0, 5'd0);
    chk("lui", {32'd0, out}, 64'h1234_0000);
    drive(6'd26, 32'h0000_ABCD, 32'd0, 5'd4, 5'd7);
    chk("ext", {32'd0, out}, 64'hBC);
    drive(6'd27, 32'hF, 32'd0, 5'd8, 5'd11);
    chk("ins", {32'd0, out}, 64'hF00);

    drive(6'd18, 32'hFFFF_FFFE, 32'd3, 5'd0, 5'd0);
    tick();
    drive(6'd22, 32'd0, 32'd0, 5'd0, 5'd0);
    chk("mult hi", {32'd0, out}, 64'hFFFF_FFFF);
    drive(6'd23, 32'd0, 32'd0, 5'd0, 5'd0);
    chk("mult lo", {32'd0, out}, 64'hFFFF_FFFA);
    drive(6'd20, 32'hFFFF_FFF9, 32'd2, 5'd0, 5'd0);
    tick();
    drive(6'd23, 32'd0, 32'd0, 5'd0, 5'd0);
    chk("div lo", {32'd0, out}, 64'hFFFF_FFFD);
    drive(6'd21, 32'd100, 32'd0, 5'd0, 5'd0);
    tick();
    drive(6'd22, 32'd0, 32'd0, 5'd0, 5'd0);
    chk("divu0 hi", {32'd0, out}, 64'hFFFF_FFFF);
    drive(6'd20, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 5'd0);
    tick();
    drive(6'd23, 32'd0, 32'd0, 5'd0, 5'd0);
    chk("div minint lo", {32'd0, out}, 64'h8000_0000);

    // MTHI then MFHI: old value before the edge, new value after, cleared by async reset
    drive(6'd22, 32'd0, 32'd0, 5'd0, 5'd0);
    chk("mfhi before mthi", {32'd0, out}, 64'd0);
    drive(6'd24, 32'h55, 32'd0, 5'd0, 5'd0);
    tick();
    drive(6'd22, 32'd0, 32'd0, 5'd0, 5'd0);
    chk("mfhi after mthi", {32'd0, out}, 64'h55);
    rst = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    chk("async reset hi", {32'd0, out}, 64'd0);
    drive(6'd24, 32'h77, 32'd0, 5'd0, 5'd0);
    tick();
    drive(6'd22, 32'd0, 32'd0, 5'd0, 5'd0);
    chk("write in reset ignored", {32'd0, out}, 64'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 1500; i++) begin
      drive(6'($urandom_range(0, 31)), pick(), pick(),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
